// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera capture slice.
//   cam_state_t  capture FSM states (SKIP, ARM, CAPTURE)
//   RGB565_*_W   RGB565 field widths
//   DEF_*_ACTIVE default resolution, shared with the display-side timing
//   CNT_W/SKIP_W counter widths
//   sat_inc      saturating increment for the 11-bit pixel/line counters
package cam_pkg;

  typedef enum logic [1:0] {
    SKIP    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } cam_state_t;

  localparam int RGB565_R_W = 5;
  localparam int RGB565_G_W = 6;
  localparam int RGB565_B_W = 5;
  localparam int PIX_W      = RGB565_R_W + RGB565_G_W + RGB565_B_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam int CNT_W  = 11;
  localparam int SKIP_W = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// cam_byte_packer: turns a byte stream into RGB565 words.
//   clk_cam  pixel clock
//   cam_rst  synchronous active-high reset
//   clear    drops any half word and zeroes the pixel count (line close / capture start)
//   byte_en  byte_in is a valid line byte this cycle
//   byte_in  sensor byte; the first byte of a pair is the high half of the word
//   wr_data  packed word {hi, lo}, held between strobes
//   wr_en    one-cycle strobe per completed word
//   pix_cnt  words completed on the current line (saturating)
//   phase    1 while a high byte is waiting for its partner
//
// Stream semantics: wr_en/wr_data form a valid-only stream with no ready;
// wr_data is meaningful only in the cycle wr_en is high and every strobe
// must be accepted by the consumer.
module cam_byte_packer
  import cam_pkg::*;
(
  input  logic             clk_cam,
  input  logic             cam_rst,
  input  logic             clear,
  input  logic             byte_en,
  input  logic [7:0]       byte_in,
  output logic [PIX_W-1:0] wr_data,
  output logic             wr_en,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             phase
);

  logic [7:0] hi;

  always_ff @(posedge clk_cam) begin
    if (cam_rst) begin
      hi      <= '0;
      phase   <= 1'b0;
      pix_cnt <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (clear) begin
        phase   <= 1'b0;
        pix_cnt <= '0;
      end else if (byte_en) begin
        if (!phase) begin
          hi    <= byte_in;
          phase <= 1'b1;
        end else begin
          wr_data <= {hi, byte_in};
          wr_en   <= 1'b1;
          pix_cnt <= sat_inc(pix_cnt);
          phase   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/cam_capture.sv
// cam_capture: DVP capture engine feeding the SDR frame buffer writer.
//   clk_cam        pixel clock, all logic on the rising edge
//   cam_rst        synchronous active-high reset
//   cam_vsync      sensor frame sync, active level set by VSYNC_POL
//   cam_href       high while line bytes are valid
//   cam_data       sensor byte
//   wr_data/wr_en  RGB565 write stream (valid-only, no back-pressure)
//   sdr_addr_set   one-cycle pulse on every vsync assert: write address to frame base
//   cam_framesync  high while in CAPTURE
//   frame_done     one-cycle pulse when a captured frame ends
//   frame_err      sticky geometry error for the current/last frame
//   dbg_state      FSM state for observation
//
// Inputs are registered once (d1) and all decisions use d1; a second
// register (d2) provides edge detection. Pin to output latency is 2 edges.
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int SKIP_FRAMES = 10,
  parameter int VSYNC_POL   = 1
)
(
  input  logic             clk_cam,
  input  logic             cam_rst,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_data,
  output logic [PIX_W-1:0] wr_data,
  output logic             wr_en,
  output logic             sdr_addr_set,
  output logic             cam_framesync,
  output logic             frame_done,
  output logic             frame_err,
  output cam_state_t       dbg_state
);

  localparam logic [CNT_W-1:0]  H_CMP    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_CMP    = CNT_W'(V_ACTIVE);
  localparam logic [SKIP_W-1:0] SKIP_CMP = SKIP_W'(SKIP_FRAMES);
  localparam logic              VS_INV   = (VSYNC_POL == 0);

  // Input stage and edge detection
  logic       vs_d1, href_d1, vs_act_d2, href_d2;
  logic [7:0] data_d1;
  logic       vs_act, assert_edge, release_edge, href_fall;

  always_ff @(posedge clk_cam) begin
    if (cam_rst) begin
      // vs_d1 resets to the inactive level so a release-level pin after
      // reset is not mistaken for an assert edge.
      vs_d1     <= VS_INV;
      href_d1   <= 1'b0;
      data_d1   <= '0;
      vs_act_d2 <= 1'b0;
      href_d2   <= 1'b0;
    end else begin
      vs_d1     <= cam_vsync;
      href_d1   <= cam_href;
      data_d1   <= cam_data;
      vs_act_d2 <= vs_act;
      href_d2   <= href_d1;
    end
  end

  assign vs_act       = vs_d1 ^ VS_INV;
  assign assert_edge  = vs_act & ~vs_act_d2;
  assign release_edge = ~vs_act & vs_act_d2;
  assign href_fall    = href_d2 & ~href_d1;

  // FSM
  cam_state_t state, state_next;
  logic       capture_start, frame_end;

  always_ff @(posedge clk_cam) begin
    if (cam_rst) state <= SKIP;
    else         state <= state_next;
  end

  // skip_cnt counts assert edges. The first assert after reset opens the
  // first complete frame, so the frame counted by skip_cnt == SKIP_FRAMES
  // is complete at the following assert edge, which is where ARM begins.
  logic [SKIP_W-1:0] skip_cnt;

  always_comb begin
    state_next    = state;
    capture_start = 1'b0;
    frame_end     = 1'b0;
    case (state)
      SKIP: begin
        if ((skip_cnt == SKIP_CMP) && (assert_edge || (SKIP_CMP == '0)))
          state_next = ARM;
      end
      ARM: begin
        if (release_edge) begin
          state_next    = CAPTURE;
          capture_start = 1'b1;
        end
      end
      CAPTURE: begin
        if (assert_edge) begin
          state_next = ARM;
          frame_end  = 1'b1;
        end
      end
      default: state_next = SKIP;
    endcase
  end

  // Packer
  logic [CNT_W-1:0] pix_cnt;
  logic             phase;
  logic             line_close, byte_en;

  assign line_close = (state == CAPTURE) && href_fall;
  assign byte_en    = (state == CAPTURE) && href_d1 && !vs_act;

  cam_byte_packer u_packer (
    .clk_cam (clk_cam),
    .cam_rst (cam_rst),
    .clear   (capture_start | line_close),
    .byte_en (byte_en),
    .byte_in (data_d1),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .pix_cnt (pix_cnt),
    .phase   (phase)
  );

  // Frame geometry checks
  logic [CNT_W-1:0] line_cnt, line_cnt_upd;
  logic             line_err, count_err;

  // A line closing in the same cycle as the frame end is counted before
  // the line-count check.
  assign line_cnt_upd = line_close ? sat_inc(line_cnt) : line_cnt;
  assign line_err     = line_close && (phase || (pix_cnt != H_CMP));
  assign count_err    = frame_end && (line_cnt_upd != V_CMP);

  always_ff @(posedge clk_cam) begin
    if (cam_rst) begin
      skip_cnt     <= '0;
      line_cnt     <= '0;
      frame_err    <= 1'b0;
      frame_done   <= 1'b0;
      sdr_addr_set <= 1'b0;
    end else begin
      sdr_addr_set <= assert_edge;
      frame_done   <= frame_end;
      if ((state == SKIP) && assert_edge && (skip_cnt != SKIP_CMP))
        skip_cnt <= skip_cnt + 1'b1;
      if (capture_start) begin
        line_cnt  <= '0;
        frame_err <= 1'b0;
      end else begin
        line_cnt <= line_cnt_upd;
        if (line_err || count_err)
          frame_err <= 1'b1;
      end
    end
  end

  assign cam_framesync = (state == CAPTURE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed bench for cam_capture with H_ACTIVE=4,
// V_ACTIVE=2, SKIP_FRAMES=1. Two instances run side by side: one with an
// active-high vsync and one with an active-low vsync fed the inverted pin,
// both checked against the same expectations.
module tb_cam_capture;
  import cam_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int SK = 1;

  // Clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, vs, href;
  logic [7:0] data;
  logic       vs_n;
  assign vs_n = ~vs;

  logic [15:0] wr_data_p, wr_data_n;
  logic        wr_en_p, wr_en_n, sdr_p, sdr_n, fs_p, fs_n;
  logic        done_p, done_n, err_p, err_n;
  cam_state_t  st_p, st_n;

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SK), .VSYNC_POL(1)) dut_p (
    .clk_cam(clk), .cam_rst(rst), .cam_vsync(vs), .cam_href(href), .cam_data(data),
    .wr_data(wr_data_p), .wr_en(wr_en_p), .sdr_addr_set(sdr_p), .cam_framesync(fs_p),
    .frame_done(done_p), .frame_err(err_p), .dbg_state(st_p)
  );

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SK), .VSYNC_POL(0)) dut_n (
    .clk_cam(clk), .cam_rst(rst), .cam_vsync(vs_n), .cam_href(href), .cam_data(data),
    .wr_data(wr_data_n), .wr_en(wr_en_n), .sdr_addr_set(sdr_n), .cam_framesync(fs_n),
    .frame_done(done_n), .frame_err(err_n), .dbg_state(st_n)
  );

  // Scoreboard
  logic [15:0] exp_q_p[$];
  logic [15:0] exp_q_n[$];
  int n_checks = 0;
  int n_fail   = 0;
  int sdr_cnt_p = 0, sdr_cnt_n = 0, done_cnt_p = 0, done_cnt_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [31:0] obs_p,
                            input logic [31:0] obs_n, input logic [31:0] exp);
    check({tag, "_p"}, obs_p, exp);
    check({tag, "_n"}, obs_n, exp);
  endtask

  // Output monitor: pops one expected word per strobe
  always @(posedge clk) begin
    logic [15:0] e;
    #1;
    if (wr_en_p) begin
      n_checks++;
      assert (exp_q_p.size() != 0) else begin
        n_fail++;
        $error("FAIL wr_en_unexpected_p observed wr_data=0x%0h expected no strobe", wr_data_p);
      end
      if (exp_q_p.size() != 0) begin
        e = exp_q_p.pop_front();
        check("wr_data_p", wr_data_p, e);
      end
    end
    if (wr_en_n) begin
      n_checks++;
      assert (exp_q_n.size() != 0) else begin
        n_fail++;
        $error("FAIL wr_en_unexpected_n observed wr_data=0x%0h expected no strobe", wr_data_n);
      end
      if (exp_q_n.size() != 0) begin
        e = exp_q_n.pop_front();
        check("wr_data_n", wr_data_n, e);
      end
    end
    if (sdr_p)  sdr_cnt_p++;
    if (sdr_n)  sdr_cnt_n++;
    if (done_p) done_cnt_p++;
    if (done_n) done_cnt_n++;
  end

  // Driver tasks
  // One vsync pulse: closes the previous frame (exp_done/exp_err) and
  // states whether the frame that follows is captured (exp_cap).
  task automatic vsync_pulse(input bit exp_done, input bit exp_err, input bit exp_cap);
    @(negedge clk); vs = 1'b1;
    @(posedge clk); #1;
    check_both("sdr_early", sdr_p, sdr_n, 0);
    @(posedge clk); #1;
    check_both("sdr_pulse", sdr_p, sdr_n, 1);
    check_both("frame_done", done_p, done_n, exp_done);
    check_both("framesync_low", fs_p, fs_n, 0);
    if (exp_done) begin
      check_both("err_at_done", err_p, err_n, exp_err);
      check("words_drained_p", exp_q_p.size(), 0);
      check("words_drained_n", exp_q_n.size(), 0);
    end
    @(posedge clk); #1;
    check_both("sdr_single", sdr_p, sdr_n, 0);
    check_both("done_single", done_p, done_n, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); vs = 1'b0;
    @(posedge clk); #1;
    check_both("fs_early", fs_p, fs_n, 0);
    @(posedge clk); #1;
    check_both("fs_rise", fs_p, fs_n, exp_cap);
    if (exp_cap) check_both("err_cleared", err_p, err_n, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_line(input int nbytes, input bit cap, input bit fixed);
    logic [7:0] hi, b;
    hi = '0;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      b = 8'($urandom_range(0, 255));
      if (fixed && i == 0) b = 8'h12;
      if (fixed && i == 1) b = 8'h34;
      href = 1'b1;
      data = b;
      if (i % 2 == 0) hi = b;
      else if (cap) begin
        exp_q_p.push_back({hi, b});
        exp_q_n.push_back({hi, b});
      end
      if (fixed && i == 1) begin
        @(posedge clk); #1;
        check_both("latency_wait", wr_en_p, wr_en_n, 0);
      end
      if (fixed && i == 2) begin
        @(posedge clk); #1;
        check_both("latency_strobe", wr_en_p, wr_en_n, 1);
        check_both("first_word", wr_data_p, wr_data_n, 16'h1234);
      end
    end
    @(negedge clk); href = 1'b0; data = '0;
    repeat (2) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    logic [7:0] b0, b1;
    rst = 1'b1; vs = 1'b0; href = 1'b0; data = '0;
    repeat (3) @(posedge clk); #1;
    check_both("rst_wr_data", wr_data_p, wr_data_n, 0);
    check_both("rst_wr_en", wr_en_p, wr_en_n, 0);
    check_both("rst_sdr", sdr_p, sdr_n, 0);
    check_both("rst_fs", fs_p, fs_n, 0);
    check_both("rst_done", done_p, done_n, 0);
    check_both("rst_err", err_p, err_n, 0);
    check_both("rst_state", st_p, st_n, SKIP);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    // Frame A discarded, frame B captured clean
    vsync_pulse(0, 0, 0);
    send_line(8, 0, 0);
    send_line(8, 0, 0);
    vsync_pulse(0, 0, 1);
    send_line(8, 1, 1);
    send_line(8, 1, 0);
    vsync_pulse(1, 0, 1);

    // Frame C: odd-length first line
    send_line(7, 1, 0);
    check_both("odd_line_err", err_p, err_n, 1);
    send_line(8, 1, 0);
    vsync_pulse(1, 1, 1);

    // Frame D: one line too many
    send_line(8, 1, 0);
    send_line(8, 1, 0);
    check_both("two_lines_ok", err_p, err_n, 0);
    send_line(8, 1, 0);
    vsync_pulse(1, 1, 1);

    // Frame E: 5-pixel line
    send_line(10, 1, 0);
    check_both("long_line_err", err_p, err_n, 1);
    send_line(8, 1, 0);
    vsync_pulse(1, 1, 1);

    // Frame F: reset in the middle of the second line
    send_line(8, 1, 0);
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    @(negedge clk); href = 1'b1; data = b0;
    @(negedge clk); data = b1;
    exp_q_p.push_back({b0, b1});
    exp_q_n.push_back({b0, b1});
    @(negedge clk); data = 8'($urandom_range(0, 255));
    @(negedge clk); rst = 1'b1; data = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    check_both("mid_rst_wr_data", wr_data_p, wr_data_n, 0);
    check_both("mid_rst_wr_en", wr_en_p, wr_en_n, 0);
    check_both("mid_rst_fs", fs_p, fs_n, 0);
    check_both("mid_rst_err", err_p, err_n, 0);
    check_both("mid_rst_state", st_p, st_n, SKIP);
    check("mid_rst_drained_p", exp_q_p.size(), 0);
    check("mid_rst_drained_n", exp_q_n.size(), 0);
    @(negedge clk); rst = 1'b0; href = 1'b0; data = '0;
    repeat (3) @(negedge clk);

    // One full frame skipped again, then capture resumes
    vsync_pulse(0, 0, 0);
    send_line(8, 0, 0);
    send_line(8, 0, 0);
    vsync_pulse(0, 0, 1);
    send_line(8, 1, 0);
    send_line(8, 1, 0);
    vsync_pulse(1, 0, 1);
    repeat (4) @(negedge clk);

    check_both("sdr_pulse_count", sdr_cnt_p, sdr_cnt_n, 9);
    check_both("frame_done_count", done_cnt_p, done_cnt_n, 5);
    check("final_drained_p", exp_q_p.size(), 0);
    check("final_drained_n", exp_q_n.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
